sort_ctrl: RTL and testbench

//  FSM sequencer for the 8-entry, 4-bit sort datapath. Loads eight samples from IN, then runs an in-place

---
 rtl/sort_pkg.sv | 30 +++
 rtl/sort_ptr_mirror.sv | 29 ++
 rtl/sort_ctrl.sv | 154 +++++++++++++++
 tb/tb_sort_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants for the 8-entry, 4-bit sort controller: depth, pointer
// width, FSM state encoding and write-mux source selects.
package sort_pkg;

    localparam int N_ENTRIES = 8;
    localparam int PTR_W     = 3;

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_ENTRIES - 1);
    localparam logic [PTR_W-1:0] PTR_PENULT = PTR_W'(N_ENTRIES - 2);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_CMP   = 3'd2;
    localparam state_t ST_SWP_T = 3'd3;
    localparam state_t ST_SWP_L = 3'd4;
    localparam state_t ST_SWP_H = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    localparam logic [1:0] WM_IN   = 2'd0;
    localparam logic [1:0] WM_TEMP = 2'd1;
    localparam logic [1:0] WM_HIGH = 2'd2;

    // True in the states that make up the sort phase (compare plus swap steps).
    function automatic logic is_sort_state(input state_t s);
        return (s == ST_CMP) || (s == ST_SWP_T) || (s == ST_SWP_L) || (s == ST_SWP_H);
    endfunction

endpackage

// File: rtl/sort_ptr_mirror.sv
// Enable counter that shadows one datapath pointer. Wraps modulo 2^W and
// flags the last entry so the controller can tell when a row or load ends.
module sort_ptr_mirror
    import sort_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_ptr,
    output logic         o_last
);

    logic [W-1:0] r_ptr;

    // Step once per enable, in lockstep with the datapath pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr  = r_ptr;
    assign o_last = &r_ptr;

endmodule

// File: rtl/sort_ctrl.sv
// Sequencer for the 8-entry sort datapath: loads eight samples, then runs an
// in-place exchange selection sort and pulses done.
// Optional cycle counter output enabled by defining SORT_CTRL_CYCLE_CNT_EN.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             gte,
    input  logic             counted,
    output logic             load_ready,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             low_en,
    output logic             high_en,
    output logic             temp_en,
    output logic             stat_en,
    output logic [1:0]       writemux,
    output logic             wa_sel
`ifdef SORT_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] w_lptr;
    logic [PTR_W-1:0] w_hptr;
    logic             w_llast;
    logic             w_hlast;
    logic             w_row_end;
    logic             w_last_row;
    logic             w_swap;

    sort_ptr_mirror #(.W(PTR_W)) u_lptr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (low_en),
        .o_ptr  (w_lptr),
        .o_last (w_llast)
    );

    sort_ptr_mirror #(.W(PTR_W)) u_hptr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (high_en),
        .o_ptr  (w_hptr),
        .o_last (w_hlast)
    );

    // Row wraps only when the datapath and the mirror agree high is at the end.
    assign w_row_end  = counted & w_hlast;
    assign w_last_row = w_row_end && (w_lptr == PTR_PENULT);
    assign w_swap     = (w_hptr > w_lptr) && gte;
    assign busy       = (r_state != ST_IDLE);
    assign stat_en    = 1'b0;

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        done        = 1'b0;
        mem_en      = 1'b0;
        low_en      = 1'b0;
        high_en     = 1'b0;
        temp_en     = 1'b0;
        writemux    = WM_IN;
        wa_sel      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (in_valid) begin
                    mem_en   = 1'b1;
                    writemux = WM_IN;
                    low_en   = 1'b1;
                    if (w_llast) w_state_nxt = ST_CMP;
                end
            end
            ST_CMP: begin
                if (w_swap) begin
                    w_state_nxt = ST_SWP_T;
                end else begin
                    high_en     = 1'b1;
                    low_en      = w_row_end;
                    w_state_nxt = w_last_row ? ST_DONE : ST_CMP;
                end
            end
            ST_SWP_T: begin
                temp_en     = 1'b1;
                w_state_nxt = ST_SWP_L;
            end
            ST_SWP_L: begin
                mem_en      = 1'b1;
                writemux    = WM_HIGH;
                wa_sel      = 1'b0;
                w_state_nxt = ST_SWP_H;
            end
            ST_SWP_H: begin
                // Write lands at the pre-increment high address.
                mem_en      = 1'b1;
                writemux    = WM_TEMP;
                wa_sel      = 1'b1;
                high_en     = 1'b1;
                low_en      = w_row_end;
                w_state_nxt = w_last_row ? ST_DONE : ST_CMP;
            end
            ST_DONE: begin
                // Wrap low from 7 back to 0 so the next run starts at 0/0.
                done        = 1'b1;
                low_en      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef SORT_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycles;

    // Sort-phase cycle count: cleared entering CMP, saturating, held after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_CMP)) begin
            r_cycles <= '0;
        end else if (is_sort_state(r_state) && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl: a behavioural datapath closes the loop,
// the driver queues expected results per run, a negedge monitor checks them.
module tb_sort_ctrl;
    import sort_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, gte, counted;
    logic [3:0] in_data;
    logic       load_ready, busy, done, mem_en, low_en, high_en, temp_en, stat_en, wa_sel;
    logic [1:0] writemux;
`ifdef SORT_CTRL_CYCLE_CNT_EN
    logic [7:0] cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sort_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .gte        (gte),
        .counted    (counted),
        .load_ready (load_ready),
        .busy       (busy),
        .done       (done),
        .mem_en     (mem_en),
        .low_en     (low_en),
        .high_en    (high_en),
        .temp_en    (temp_en),
        .stat_en    (stat_en),
        .writemux   (writemux),
        .wa_sel     (wa_sel)
`ifdef SORT_CTRL_CYCLE_CNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    // Behavioural datapath: memory, two pointers, temp register.
    logic [3:0] mem [8];
    logic [2:0] a_ptr, b_ptr;
    logic [3:0] temp;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'd0;
        temp = 4'd0;
    end

    always @(posedge clk) begin
        if (rst) begin
            a_ptr <= 3'd0;
            b_ptr <= 3'd0;
        end else begin
            if (mem_en)
                mem[wa_sel ? b_ptr : a_ptr] <= (writemux == 2'd0) ? in_data :
                                               (writemux == 2'd1) ? temp : mem[b_ptr];
            if (temp_en) temp <= mem[a_ptr];
            if (low_en) a_ptr <= a_ptr + 3'd1;
            if (high_en) b_ptr <= b_ptr + 3'd1;
        end
    end

    assign gte     = (mem[a_ptr] >= mem[b_ptr]);
    assign counted = (b_ptr == 3'd7);

    function automatic logic [31:0] mem_pack();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = mem[i];
        return r;
    endfunction

    function automatic logic [31:0] outs();
        return {21'd0, load_ready, busy, done, mem_en, low_en, high_en, temp_en, stat_en,
                writemux, wa_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard queues; -1 means that field is not checked for the run.
    logic [31:0] q_sorted [$];
    int          q_cyc [$];
    int          q_swr [$];
    int          q_cnt [$];

    task automatic expect_run(input logic [31:0] s, input int cyc, input int swr, input int cnt);
        q_sorted.push_back(s);
        q_cyc.push_back(cyc);
        q_swr.push_back(swr);
        q_cnt.push_back(cnt);
    endtask

    // Monitor: counts sort-phase cycles and swap writes, checks on each done.
    int sc_cnt = 0;
    int sc_swr = 0;
    int wm_bad = 0;
    bit chk_idle = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e_s;
        int          e_c, e_w, e_n;
        if (chk_idle) begin
            chk_idle = 1'b0;
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
        if (load_ready) begin
            sc_cnt = 0;
            sc_swr = 0;
            wm_bad = 0;
        end else if (busy) begin
            sc_cnt++;
            if (mem_en) sc_swr++;
        end
        if (mem_en && writemux == 2'd3) wm_bad++;
        if (done) begin
            if (q_sorted.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e_s = q_sorted.pop_front();
                e_c = q_cyc.pop_front();
                e_w = q_swr.pop_front();
                e_n = q_cnt.pop_front();
                chk("sorted_mem", mem_pack(), e_s);
                chk("writemux_legal", wm_bad, 0);
                if (e_c >= 0) chk("sort_cycles", sc_cnt, e_c);
                if (e_w >= 0) chk("swap_writes", sc_swr, e_w);
`ifdef SORT_CTRL_CYCLE_CNT_EN
                if (e_n >= 0) chk("cycles_port", {24'd0, cycles}, e_n);
`endif
                chk_idle = 1'b1;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Sample i is nibble i; one idle bubble before sample 3.
    task automatic do_load(input logic [31:0] v);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = v[4*i +: 4];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", outs(), 32'd0);
`ifdef SORT_CTRL_CYCLE_CNT_EN
        chk("reset_cycles", {24'd0, cycles}, 32'd0);
`endif

        // 1: mixed values with duplicates
        expect_run(32'hF9732210, -1, -1, -1);
        do_start();
        do_load(32'h922F0173);
        wait_idle(400);

        // 2: already ascending, no swaps
        expect_run(32'h76543210, 57, 0, 56);
        do_start();
        do_load(32'h76543210);
        wait_idle(400);

        // 3: descending
        expect_run(32'h76543210, -1, -1, -1);
        do_start();
        do_load(32'h01234567);
        wait_idle(400);

        // 4: all equal, every pair swaps
        expect_run(32'h55555555, 141, 56, 140);
        do_start();
        do_load(32'h55555555);
        wait_idle(400);

        // 5: reset mid-sort, then a fresh run
        do_start();
        do_load(32'h13579BDF);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_sort_outputs", outs(), 32'd0);
`ifdef SORT_CTRL_CYCLE_CNT_EN
        chk("rst_mid_sort_cycles", {24'd0, cycles}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        expect_run(32'hEC855310, -1, -1, -1);
        do_start();
        do_load(32'h18E3550C);
        wait_idle(400);

        // 6: in_valid in IDLE and start during the sort are both ignored
        in_valid = 1'b1;
        in_data  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle_in_valid_ignored", outs(), 32'd0);
        end
        in_valid = 1'b0;
        expect_run(32'h76543210, 57, 0, 56);
        do_start();
        do_load(32'h76543210);
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(400);

        chk("queue_drained", q_sorted.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
